// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO.
package fifo_pkg;

    // Number of entries for a given pointer width
    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    // Registered occupancy flags
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem_array.sv
// 1W/1R register file: synchronous write, asynchronous read. Not reset.
module fifo_mem_array
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);

    logic [DATA_WIDTH-1:0] r_mem [fifo_depth(ADDR_WIDTH)];

    // Store the write word at the write address
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_mem[w_addr] <= w_data;
        end
    end

    assign r_data = r_mem[r_addr];

endmodule

// File: rtl/sync_fifo_buffer.sv
// Single-clock FIFO with registered flags, fill count and sticky error flags.
// Build option: FIFO_FWFT_EN selects first-word fall-through read behaviour;
// when undefined, reads return data one cycle after an accepted rd.
module sync_fifo_buffer
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 1,
    parameter int unsigned AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_param_check
        $fatal(1, "sync_fifo_buffer: need AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [ADDR_WIDTH-1:0] r_w_ptr;
    logic [ADDR_WIDTH-1:0] r_r_ptr;
    logic [CNT_W-1:0]      r_count;
    fifo_status_t          r_status;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic [CNT_W-1:0]      w_count_nxt;
    fifo_status_t          w_status_nxt;
    logic                  w_overflow_nxt;
    logic                  w_underflow_nxt;
    logic [DATA_WIDTH-1:0] w_mem_rd;

    // Accept decisions, next occupancy, flag decode and sticky error update
    always_comb begin
        w_rd_acc        = rd && !r_status.empty;
        w_wr_acc        = wr && (!r_status.full || w_rd_acc);
        w_count_nxt     = r_count;
        w_overflow_nxt  = r_overflow;
        w_underflow_nxt = r_underflow;

        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase

        w_status_nxt.full         = (w_count_nxt == CNT_W'(DEPTH));
        w_status_nxt.empty        = (w_count_nxt == '0);
        w_status_nxt.almost_full  = (w_count_nxt >= CNT_W'(AF_LEVEL));
        w_status_nxt.almost_empty = (w_count_nxt <= CNT_W'(AE_LEVEL));

        // Clear wins over a same-cycle set
        if (err_clr) begin
            w_overflow_nxt  = 1'b0;
            w_underflow_nxt = 1'b0;
        end else begin
            w_overflow_nxt  = r_overflow  | (wr && !w_wr_acc);
            w_underflow_nxt = r_underflow | (rd && r_status.empty);
        end
    end

    // Pointers, occupancy, flags and error state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_w_ptr     <= '0;
            r_r_ptr     <= '0;
            r_count     <= '0;
            r_status    <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_w_ptr <= r_w_ptr + ADDR_WIDTH'(1);
            end
            if (w_rd_acc) begin
                r_r_ptr <= r_r_ptr + ADDR_WIDTH'(1);
            end
            r_count     <= w_count_nxt;
            r_status    <= w_status_nxt;
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    fifo_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk    (clk),
        .w_en   (w_wr_acc),
        .w_addr (r_w_ptr),
        .w_data (w_data),
        .r_addr (r_r_ptr),
        .r_data (w_mem_rd)
    );

`ifdef FIFO_FWFT_EN
    // Head word is presented directly; rd pops what is shown
    assign r_data  = w_mem_rd;
    assign r_valid = !r_status.empty;
`else
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    // Registered read path: data appears the cycle after an accepted read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= w_mem_rd;
            end
        end
    end

    assign r_data  = r_rd_data;
    assign r_valid = r_rd_valid;
`endif

    assign full         = r_status.full;
    assign empty        = r_status.empty;
    assign almost_full  = r_status.almost_full;
    assign almost_empty = r_status.almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Directed self-checking bench for sync_fifo_buffer (default parameters).
// Handles both read modes; FIFO_FWFT_EN selects the matching expectations.
module tb_sync_fifo_buffer;

`ifdef FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       wr;
    logic [7:0] w_data;
    logic       rd;
    logic [7:0] r_data;
    logic       r_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;
    logic       err_clr;

    int n_vec = 0;
    int n_err = 0;

    sync_fifo_buffer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr           (wr),
        .w_data       (w_data),
        .rd           (rd),
        .r_data       (r_data),
        .r_valid      (r_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr = 1'b1;
        w_data = d;
        step();
        wr = 1'b0;
    endtask

    task automatic pop(input logic [7:0] expd);
        if (FWFT) begin
            chk("pop_valid", 32'(r_valid), 32'd1);
            chk("pop_data", 32'(r_data), 32'(expd));
        end
        rd = 1'b1;
        step();
        rd = 1'b0;
        if (!FWFT) begin
            chk("pop_valid", 32'(r_valid), 32'd1);
            chk("pop_data", 32'(r_data), 32'(expd));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
        err_clr = 1'b0;
        w_data  = '0;
        step();
        step();

        // Reset state
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_aempty", 32'(almost_empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(r_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_unf", 32'(underflow), 32'd0);
        if (!FWFT) chk("rst_rdata", 32'(r_data), 32'd0);
        reset_n = 1'b1;
        step();

        // Mid-stream reset, asserted between edges with a read pending
        push(8'h01);
        push(8'h02);
        push(8'h03);
        chk("mid_count3", 32'(count), 32'd3);
        rd = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_empty", 32'(empty), 32'd1);
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_valid", 32'(r_valid), 32'd0);
        rd = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        chk("post_valid", 32'(r_valid), 32'd0);
        chk("post_count", 32'(count), 32'd0);
        chk("post_empty", 32'(empty), 32'd1);

        // Fill to full
        for (int i = 0; i < 8; i++) begin
            push(8'(8'h10 + i));
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_afull", 32'(almost_full), 32'((i + 1) >= 7));
            chk("fill_aempty", 32'(almost_empty), 32'((i + 1) <= 1));
            chk("fill_full", 32'(full), 32'((i + 1) == 8));
            chk("fill_empty", 32'(empty), 32'd0);
        end
        push(8'h99);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_full", 32'(full), 32'd1);

        // Drain in order
        for (int i = 0; i < 8; i++) begin
            pop(8'(8'h10 + i));
            chk("drain_count", 32'(count), 32'(7 - i));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_aempty", 32'(almost_empty), 32'd1);
        step();
        chk("idle_valid", 32'(r_valid), 32'd0);
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk("unf_set", 32'(underflow), 32'd1);
        chk("unf_count", 32'(count), 32'd0);
        chk("unf_valid", 32'(r_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_unf", 32'(underflow), 32'd0);

        // Clear beats a same-cycle underflow
        rd = 1'b1;
        err_clr = 1'b1;
        step();
        rd = 1'b0;
        err_clr = 1'b0;
        chk("clr_prio", 32'(underflow), 32'd0);

        // Pointer wrap
        for (int i = 0; i < 5; i++) push(8'(8'h20 + i));
        for (int i = 0; i < 5; i++) pop(8'(8'h20 + i));
        for (int i = 0; i < 6; i++) push(8'(8'h30 + i));
        chk("wrap_count", 32'(count), 32'd6);
        for (int i = 0; i < 6; i++) pop(8'(8'h30 + i));
        chk("wrap_empty", 32'(empty), 32'd1);

        // Simultaneous write and read while full
        for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
        chk("wr_rd_full_pre", 32'(full), 32'd1);
        if (FWFT) chk("wr_rd_head", 32'(r_data), 32'h40);
        wr = 1'b1;
        rd = 1'b1;
        w_data = 8'hAA;
        step();
        wr = 1'b0;
        rd = 1'b0;
        if (!FWFT) chk("wr_rd_data", 32'(r_data), 32'h40);
        chk("wr_rd_count", 32'(count), 32'd8);
        chk("wr_rd_ovf", 32'(overflow), 32'd0);
        chk("wr_rd_full", 32'(full), 32'd1);
        for (int i = 1; i < 8; i++) pop(8'(8'h40 + i));
        pop(8'hAA);
        chk("wr_rd_empty", 32'(empty), 32'd1);

        // Simultaneous write and read while empty
        wr = 1'b1;
        rd = 1'b1;
        w_data = 8'h5A;
        step();
        wr = 1'b0;
        rd = 1'b0;
        chk("emp_wr_rd_count", 32'(count), 32'd1);
        chk("emp_wr_rd_unf", 32'(underflow), 32'd1);
        chk("emp_wr_rd_empty", 32'(empty), 32'd0);
        chk("emp_wr_rd_valid", 32'(r_valid), 32'(FWFT));
        pop(8'h5A);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("emp_clr_unf", 32'(underflow), 32'd0);

        if (FWFT) begin
            // Fall-through of a single word into an empty FIFO
            push(8'h3C);
            chk("fwft_valid", 32'(r_valid), 32'd1);
            chk("fwft_data", 32'(r_data), 32'h3C);
            rd = 1'b1;
            step();
            rd = 1'b0;
            chk("fwft_empty", 32'(empty), 32'd1);
            chk("fwft_valid_off", 32'(r_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
